// File: rtl/vc8_ring_drain.sv
// Consumer for the VC-8 point ring: fetches {intens,y,x} entries from video RAM and
// offers them to the renderer, either consuming them (DRAIN) or re-walking them (REPLAY).
module vc8_ring_drain #(
    parameter int AW     = 15,
    parameter int RD_LAT = 3
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          enable,
    input  logic          replay,
    input  logic [AW-1:0] insert,
    input  logic          bump,
    output logic [AW-1:0] vidaddrb,
    output logic          videnabb,
    input  logic [21:0]   viddatab,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [9:0]    pix_x,
    output logic [9:0]    pix_y,
    output logic [1:0]    pix_intens,
    output logic [AW-1:0] remove,
    output logic          frame_done,
    output logic [15:0]   overruns
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] cursor;
    logic          mode;   // latched replay for the point in flight
    logic          stale;

    logic [AW-1:0] src;
    logic          accept, bump_hit, stale_now, rem_inc, cur_inc;

    assign src       = replay ? cursor : remove;
    assign accept    = (state == PRESENT) && pix_valid && pix_ready;
    // The writer overwrote the very slot we are fetching or offering.
    assign bump_hit  = bump && !mode && (state != IDLE) && (vidaddrb == remove);
    assign stale_now = stale | bump_hit;
    // A same-cycle bump and accept name the same slot, so remove moves once.
    assign rem_inc   = bump | (accept & ~mode & ~stale_now);
    assign cur_inc   = (accept & mode) | (bump & (cursor == remove));

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            cursor     <= '0;
            mode       <= 1'b0;
            stale      <= 1'b0;
            vidaddrb   <= '0;
            videnabb   <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_intens <= '0;
            remove     <= '0;
            frame_done <= 1'b0;
            overruns   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (rem_inc)  remove <= remove + 1'b1;
            if (cur_inc)  cursor <= cursor + 1'b1;
            if (bump_hit) stale  <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable && (src != insert)) begin
                        vidaddrb <= src;
                        videnabb <= 1'b1;
                        cnt      <= '0;
                        mode     <= replay;
                        stale    <= 1'b0;
                        state    <= FETCH;
                    end else if (enable && replay && (cursor != remove)) begin
                        // End of a replay pass; restart from the oldest live slot.
                        cursor     <= bump ? remove + 1'b1 : remove;
                        frame_done <= 1'b1;
                    end
                end
                FETCH: begin
                    if (cnt == CW'(RD_LAT - 1)) begin
                        videnabb <= 1'b0;
                        if (stale_now) begin
                            if (overruns != 16'hFFFF) overruns <= overruns + 1'b1;
                            state <= IDLE;
                        end else begin
                            pix_x      <= viddatab[9:0];
                            pix_y      <= viddatab[19:10];
                            pix_intens <= viddatab[21:20];
                            pix_valid  <= 1'b1;
                            state      <= PRESENT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vc8_ring_drain.sv
// Directed bench for vc8_ring_drain: reset, empty ring, drain, backpressure,
// pointer wrap, replay passes, overrun discard and reset during a fetch.
module tb_vc8_ring_drain;

    localparam int AW = 15;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic          enable = 1'b0;
    logic          replay = 1'b0;
    logic [AW-1:0] insert = '0;
    logic          bump = 1'b0;
    logic [AW-1:0] vidaddrb;
    logic          videnabb;
    logic [21:0]   viddatab = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic [1:0]    pix_intens;
    logic [AW-1:0] remove;
    logic          frame_done;
    logic [15:0]   overruns;

    int checks = 0;
    int errors = 0;

    logic [21:0] mem [0:(1<<AW)-1];

    vc8_ring_drain #(.AW(AW), .RD_LAT(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .replay(replay),
        .insert(insert), .bump(bump), .vidaddrb(vidaddrb), .videnabb(videnabb),
        .viddatab(viddatab), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_intens(pix_intens), .remove(remove),
        .frame_done(frame_done), .overruns(overruns)
    );

    always #5 CLOCK = ~CLOCK;

    // Registered-read RAM model
    always @(posedge CLOCK) if (videnabb) viddatab <= mem[vidaddrb];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    // Wait for a point to be offered; returns enable-high cycles and last address.
    task automatic wait_pix(output int en_n, output logic [AW-1:0] addr);
        bit ok;
        ok   = 1'b0;
        en_n = 0;
        addr = '0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (videnabb) begin
                en_n++;
                addr = vidaddrb;
            end
            if (pix_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("pix_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        logic [21:0] held;
        bit seen, stable;
        logic [AW-1:0] addrs [$];
        int fd_cnt, fd_pos;
        logic en_prev;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[5]     = 22'h2ABCDE;
        mem[6]     = 22'h123456;
        mem[32767] = 22'h155555;
        mem[0]     = 22'h0AAAAA;

        // Reset state
        tick; tick;
        RESET = 1'b0;
        chk("rst_addr",   32'(vidaddrb), 32'd0);
        chk("rst_en",     32'(videnabb), 32'd0);
        chk("rst_valid",  32'(pix_valid), 32'd0);
        chk("rst_pix",    {10'd0, pix_intens, pix_y, pix_x}, 32'd0);
        chk("rst_remove", 32'(remove), 32'd0);
        chk("rst_fd",     32'(frame_done), 32'd0);
        chk("rst_ovr",    32'(overruns), 32'd0);

        // Empty ring: nothing fetched
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (videnabb || pix_valid) seen = 1'b1;
        end
        chk("empty_idle", {31'd0, seen}, 32'd0);
        enable = 1'b0;

        // Drain one point from slot 5
        bump = 1'b1;
        repeat (5) tick;
        bump = 1'b0;
        chk("bump_rem5", 32'(remove), 32'd5);
        insert = 15'd6; pix_ready = 1'b1; enable = 1'b1;
        wait_pix(n, a);
        chk("drain_addr", 32'(a), 32'd5);
        chk("drain_en3",  32'(n), 32'd3);
        chk("drain_int",  32'(pix_intens), 32'd2);
        chk("drain_y",    32'(pix_y), 32'h2AF);
        chk("drain_x",    32'(pix_x), 32'h0DE);
        tick;
        chk("drain_rem",  32'(remove), 32'd6);
        chk("drain_vld0", 32'(pix_valid), 32'd0);

        // Backpressure on slot 6
        pix_ready = 1'b0; insert = 15'd7;
        wait_pix(n, a);
        held = {pix_intens, pix_y, pix_x};
        chk("bp_data", 32'(held), 32'h123456);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (!pix_valid || {pix_intens, pix_y, pix_x} !== held || remove !== 15'd6) stable = 1'b0;
        end
        chk("bp_stable", {31'd0, stable}, 32'd1);
        pix_ready = 1'b1;
        tick;
        chk("bp_rem", 32'(remove), 32'd7);
        chk("bp_vld0", 32'(pix_valid), 32'd0);

        // Wrap: move remove to 32767 then drain two points
        enable = 1'b0;
        bump = 1'b1;
        repeat (32767 - 7) tick;
        bump = 1'b0;
        chk("wrap_rem0", 32'(remove), 32'd32767);
        insert = 15'd1; enable = 1'b1;
        wait_pix(n, a);
        chk("wrap_a1", 32'(a), 32'd32767);
        chk("wrap_d1", 32'({pix_intens, pix_y, pix_x}), 32'h155555);
        tick;
        wait_pix(n, a);
        chk("wrap_a2", 32'(a), 32'd0);
        chk("wrap_d2", 32'({pix_intens, pix_y, pix_x}), 32'h0AAAAA);
        tick;
        chk("wrap_rem", 32'(remove), 32'd1);

        // Replay: two passes over 0,1,2
        enable = 1'b0;
        RESET = 1'b1; tick; RESET = 1'b0;
        mem[1] = 22'h000111; mem[2] = 22'h000222;
        insert = 15'd3; replay = 1'b1; enable = 1'b1;
        fd_cnt = 0; fd_pos = -1; en_prev = 1'b0;
        for (int i = 0; i < 80 && addrs.size() < 6; i++) begin
            tick;
            if (videnabb && !en_prev) addrs.push_back(vidaddrb);
            if (frame_done) begin
                fd_cnt++;
                fd_pos = addrs.size();
            end
            en_prev = videnabb;
        end
        chk("rp_count", 32'(addrs.size()), 32'd6);
        for (int i = 0; i < 6 && i < addrs.size(); i++)
            chk($sformatf("rp_addr%0d", i), 32'(addrs[i]), 32'(i % 3));
        chk("rp_fd_cnt", 32'(fd_cnt), 32'd1);
        chk("rp_fd_pos", 32'(fd_pos), 32'd3);
        chk("rp_rem",    32'(remove), 32'd0);
        enable = 1'b0; replay = 1'b0;
        repeat (20) tick;

        // Overrun: bump hits the slot being fetched
        enable = 1'b1;
        tick;
        chk("ov_launch", 32'({videnabb, vidaddrb}), 32'({1'b1, 15'd0}));
        enable = 1'b0; bump = 1'b1;
        tick;
        bump = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (pix_valid) seen = 1'b1;
        end
        chk("ov_novalid", {31'd0, seen}, 32'd0);
        chk("ov_count",   32'(overruns), 32'd1);
        chk("ov_rem",     32'(remove), 32'd1);
        chk("ov_en0",     32'(videnabb), 32'd0);

        // Reset in the middle of a fetch
        enable = 1'b1;
        tick; tick;
        chk("rf_inflight", 32'({videnabb, vidaddrb}), 32'({1'b1, 15'd1}));
        RESET = 1'b1;
        tick;
        RESET = 1'b0; enable = 1'b0;
        chk("rf_en",    32'(videnabb), 32'd0);
        chk("rf_valid", 32'(pix_valid), 32'd0);
        chk("rf_addr",  32'(vidaddrb), 32'd0);
        chk("rf_rem",   32'(remove), 32'd0);
        chk("rf_ovr",   32'(overruns), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (pix_valid || videnabb) seen = 1'b1;
        end
        chk("rf_quiet", {31'd0, seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
